// File: rtl/conv_mac_sequencer_if.sv
// Bus bundle between the serial convolution sequencer and its surroundings:
// the start/busy/done handshake, the three 1-cycle-latency read ports
// (input tensor, weights, bias) and the output buffer write port.
// Signal suffixes are named from the sequencer's point of view.
interface conv_mac_sequencer_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic                  start_i;
    logic                  busy_o;
    logic                  done_o;

    logic                  in_rd_en_o;
    logic [ADDR_WIDTH-1:0] in_addr_o;
    logic [DATA_WIDTH-1:0] in_rdata_i;

    logic                  w_rd_en_o;
    logic [ADDR_WIDTH-1:0] w_addr_o;
    logic [DATA_WIDTH-1:0] w_rdata_i;

    logic                  b_rd_en_o;
    logic [ADDR_WIDTH-1:0] b_addr_o;
    logic [DATA_WIDTH-1:0] b_rdata_i;

    logic                  out_we_o;
    logic [ADDR_WIDTH-1:0] out_addr_o;
    logic [DATA_WIDTH-1:0] out_data_o;

    // The sequencer side: issues reads and writes, consumes read data.
    modport master (
        input  start_i, in_rdata_i, w_rdata_i, b_rdata_i,
        output busy_o, done_o,
               in_rd_en_o, in_addr_o,
               w_rd_en_o, w_addr_o,
               b_rd_en_o, b_addr_o,
               out_we_o, out_addr_o, out_data_o
    );

    // The memory / controller side.
    modport slave (
        output start_i, in_rdata_i, w_rdata_i, b_rdata_i,
        input  busy_o, done_o,
               in_rd_en_o, in_addr_o,
               w_rd_en_o, w_addr_o,
               b_rd_en_o, b_addr_o,
               out_we_o, out_addr_o, out_data_o
    );
endinterface

// File: rtl/conv_mac_sequencer.sv
// Serial NCHW convolution engine built around one shared MAC.
// Per output pixel: one BIAS fetch cycle, one MAC cycle per tap, one DRAIN
// cycle to fold in the final product, and one WRITE cycle, so every pixel
// costs TAPS+3 cycles. Read data arrives one cycle after its enable, so the
// accumulator always consumes the product of the tap issued the cycle before.
// Padding taps never touch the input memory; a delayed pad flag zeroes their
// product instead. Arithmetic wraps modulo 2^DATA_WIDTH.
module conv_mac_sequencer #(
    parameter int IN_CHANNELS  = 2,
    parameter int OUT_CHANNELS = 1,
    parameter int IN_HEIGHT    = 4,
    parameter int IN_WIDTH     = 4,
    parameter int OUT_HEIGHT   = 2,
    parameter int OUT_WIDTH    = 2,
    parameter int KERNEL_SIZE  = 2,
    parameter int STRIDE       = 2,
    parameter int PADDING      = 0,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    conv_mac_sequencer_if.master bus
);

    // Loop counters are kept generously wide so any realistic layer fits.
    localparam int CW = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BIAS,
        S_MAC,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    // Outer (pixel) loop: out_ch, out_h, out_w.
    logic [CW-1:0] outCh_q,  outCh_d;
    logic [CW-1:0] outRow_q, outRow_d;
    logic [CW-1:0] outCol_q, outCol_d;

    // Inner (tap) loop: in_ch, k_h, k_w.
    logic [CW-1:0] inCh_q, inCh_d;
    logic [CW-1:0] kRow_q, kRow_d;
    logic [CW-1:0] kCol_q, kCol_d;

    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic                  pad_q, pad_d;

    int                    inRow;
    int                    inCol;
    int                    inAddrInt;
    int                    wAddrInt;
    int                    outAddrInt;
    logic                  inBounds;
    logic                  firstTap;
    logic                  lastTap;
    logic                  lastPixel;
    logic [DATA_WIDTH-1:0] product;

    // Tap geometry, flat NCHW addresses and the loop-boundary flags.
    always_comb begin
        inRow      = int'(outRow_q) * STRIDE + int'(kRow_q) - PADDING;
        inCol      = int'(outCol_q) * STRIDE + int'(kCol_q) - PADDING;
        inBounds   = (inRow >= 0) && (inRow < IN_HEIGHT) &&
                     (inCol >= 0) && (inCol < IN_WIDTH);
        inAddrInt  = int'(inCh_q) * IN_HEIGHT * IN_WIDTH + inRow * IN_WIDTH + inCol;
        wAddrInt   = ((int'(outCh_q) * IN_CHANNELS + int'(inCh_q)) * KERNEL_SIZE
                      + int'(kRow_q)) * KERNEL_SIZE + int'(kCol_q);
        outAddrInt = (int'(outCh_q) * OUT_HEIGHT + int'(outRow_q)) * OUT_WIDTH
                     + int'(outCol_q);
        firstTap   = (inCh_q == '0) && (kRow_q == '0) && (kCol_q == '0);
        lastTap    = (inCh_q == CW'(IN_CHANNELS - 1)) &&
                     (kRow_q == CW'(KERNEL_SIZE - 1)) &&
                     (kCol_q == CW'(KERNEL_SIZE - 1));
        lastPixel  = (outCh_q  == CW'(OUT_CHANNELS - 1)) &&
                     (outRow_q == CW'(OUT_HEIGHT - 1)) &&
                     (outCol_q == CW'(OUT_WIDTH - 1));
    end

    // Product of the tap read last cycle, truncated; padding taps contribute 0.
    always_comb begin
        product = '0;
        if (!pad_q) begin
            product = bus.in_rdata_i * bus.w_rdata_i;
        end
    end

    // Bus outputs decoded from the state; addresses are held at 0 whenever
    // their enable is low so the idle/reset bus is quiet.
    always_comb begin
        bus.busy_o     = 1'b0;
        bus.done_o     = 1'b0;
        bus.in_rd_en_o = 1'b0;
        bus.in_addr_o  = '0;
        bus.w_rd_en_o  = 1'b0;
        bus.w_addr_o   = '0;
        bus.b_rd_en_o  = 1'b0;
        bus.b_addr_o   = '0;
        bus.out_we_o   = 1'b0;
        bus.out_addr_o = '0;
        bus.out_data_o = '0;
        case (state_q)
            S_BIAS: begin
                bus.busy_o    = 1'b1;
                bus.b_rd_en_o = 1'b1;
                bus.b_addr_o  = ADDR_WIDTH'(outCh_q);
            end
            S_MAC: begin
                bus.busy_o    = 1'b1;
                bus.w_rd_en_o = 1'b1;
                bus.w_addr_o  = ADDR_WIDTH'(wAddrInt);
                if (inBounds) begin
                    bus.in_rd_en_o = 1'b1;
                    bus.in_addr_o  = ADDR_WIDTH'(inAddrInt);
                end
            end
            S_DRAIN: begin
                bus.busy_o = 1'b1;
            end
            S_WRITE: begin
                bus.busy_o     = 1'b1;
                bus.out_we_o   = 1'b1;
                bus.out_addr_o = ADDR_WIDTH'(outAddrInt);
                bus.out_data_o = acc_q;
            end
            S_DONE: begin
                bus.done_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Next-state logic: sequencing, loop counter stepping and accumulation.
    always_comb begin
        state_d  = state_q;
        outCh_d  = outCh_q;
        outRow_d = outRow_q;
        outCol_d = outCol_q;
        inCh_d   = inCh_q;
        kRow_d   = kRow_q;
        kCol_d   = kCol_q;
        acc_d    = acc_q;
        pad_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    state_d = S_BIAS;
                end
            end
            S_BIAS: begin
                state_d = S_MAC;
            end
            S_MAC: begin
                pad_d = !inBounds;
                if (firstTap) begin
                    acc_d = bus.b_rdata_i;
                end else begin
                    acc_d = acc_q + product;
                end
                if (kCol_q == CW'(KERNEL_SIZE - 1)) begin
                    kCol_d = '0;
                    if (kRow_q == CW'(KERNEL_SIZE - 1)) begin
                        kRow_d = '0;
                        if (inCh_q == CW'(IN_CHANNELS - 1)) begin
                            inCh_d = '0;
                        end else begin
                            inCh_d = inCh_q + CW'(1);
                        end
                    end else begin
                        kRow_d = kRow_q + CW'(1);
                    end
                end else begin
                    kCol_d = kCol_q + CW'(1);
                end
                if (lastTap) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                acc_d   = acc_q + product;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (lastPixel) begin
                    outCh_d  = '0;
                    outRow_d = '0;
                    outCol_d = '0;
                    state_d  = S_DONE;
                end else begin
                    state_d = S_BIAS;
                    if (outCol_q == CW'(OUT_WIDTH - 1)) begin
                        outCol_d = '0;
                        if (outRow_q == CW'(OUT_HEIGHT - 1)) begin
                            outRow_d = '0;
                            outCh_d  = outCh_q + CW'(1);
                        end else begin
                            outRow_d = outRow_q + CW'(1);
                        end
                    end else begin
                        outCol_d = outCol_q + CW'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counters and accumulator; reset aborts a pass immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            outCh_q  <= '0;
            outRow_q <= '0;
            outCol_q <= '0;
            inCh_q   <= '0;
            kRow_q   <= '0;
            kCol_q   <= '0;
            acc_q    <= '0;
            pad_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            outCh_q  <= outCh_d;
            outRow_q <= outRow_d;
            outCol_q <= outCol_d;
            inCh_q   <= inCh_d;
            kRow_q   <= kRow_d;
            kCol_q   <= kCol_d;
            acc_q    <= acc_d;
            pad_q    <= pad_d;
        end
    end

endmodule

// File: tb/tb_conv_mac_sequencer.sv
// Bench for conv_mac_sequencer. Two instances run side by side from one start:
// dut0 uses the default layer (2 in ch, 4x4 input, 2x2 kernel, stride 2),
// dut1 a padded layer (1 in ch, 2 out ch, 2x2 input, stride 1, pad 1, 3x3 out).
// A reference model computes every output with plain loops and predicts the
// per-cycle bus activity from the pixel/tap schedule.
module tb_conv_mac_sequencer;

    localparam int cfgInCh   [2] = '{2, 1};
    localparam int cfgOutCh  [2] = '{1, 2};
    localparam int cfgInH    [2] = '{4, 2};
    localparam int cfgInW    [2] = '{4, 2};
    localparam int cfgOutH   [2] = '{2, 3};
    localparam int cfgOutW   [2] = '{2, 3};
    localparam int cfgK      [2] = '{2, 2};
    localparam int cfgStride [2] = '{2, 1};
    localparam int cfgPad    [2] = '{0, 1};
    localparam int cfgTaps   [2] = '{8, 4};
    localparam int cfgPix    [2] = '{4, 18};
    localparam int cfgInSize [2] = '{32, 4};
    localparam int cfgWSize  [2] = '{8, 8};
    localparam int cfgBSize  [2] = '{1, 2};
    localparam int doneAtLit [2] = '{44, 126};
    localparam int lit1 [18] = '{1, 3, 2, 4, 10, 6, 3, 7, 4,
                                 -9, -7, -8, -6, 0, -4, -7, -3, -6};

    logic clk;
    logic rst;
    logic start;

    int inMem  [2][0:31];
    int wMem   [2][0:7];
    int bMem   [2][0:1];
    int expOut [2][0:17];

    bit mRun    [2];
    int mCyc    [2];
    int passIdx [2] = '{-1, -1};
    int wrCnt   [2];

    int assertCount = 0;
    int failCount   = 0;

    conv_mac_sequencer_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus0 ();
    conv_mac_sequencer_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus1 ();

    assign bus0.start_i = start;
    assign bus1.start_i = start;

    conv_mac_sequencer #(
        .IN_CHANNELS(2), .OUT_CHANNELS(1), .IN_HEIGHT(4), .IN_WIDTH(4),
        .OUT_HEIGHT(2), .OUT_WIDTH(2), .KERNEL_SIZE(2), .STRIDE(2),
        .PADDING(0), .DATA_WIDTH(32), .ADDR_WIDTH(16)
    ) dut0 (
        .clk(clk),
        .rst(rst),
        .bus(bus0)
    );

    conv_mac_sequencer #(
        .IN_CHANNELS(1), .OUT_CHANNELS(2), .IN_HEIGHT(2), .IN_WIDTH(2),
        .OUT_HEIGHT(3), .OUT_WIDTH(3), .KERNEL_SIZE(2), .STRIDE(1),
        .PADDING(1), .DATA_WIDTH(32), .ADDR_WIDTH(16)
    ) dut1 (
        .clk(clk),
        .rst(rst),
        .bus(bus1)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memories for dut0: registered reads, out-of-range reads return garbage.
    always @(posedge clk) begin
        if (bus0.in_rd_en_o)
            bus0.in_rdata_i <= (int'(bus0.in_addr_o) < cfgInSize[0]) ? inMem[0][int'(bus0.in_addr_o)] : 32'hDEADBEEF;
        if (bus0.w_rd_en_o)
            bus0.w_rdata_i <= (int'(bus0.w_addr_o) < cfgWSize[0]) ? wMem[0][int'(bus0.w_addr_o)] : 32'hDEADBEEF;
        if (bus0.b_rd_en_o)
            bus0.b_rdata_i <= (int'(bus0.b_addr_o) < cfgBSize[0]) ? bMem[0][int'(bus0.b_addr_o)] : 32'hDEADBEEF;
    end

    // Memories for dut1, same behaviour.
    always @(posedge clk) begin
        if (bus1.in_rd_en_o)
            bus1.in_rdata_i <= (int'(bus1.in_addr_o) < cfgInSize[1]) ? inMem[1][int'(bus1.in_addr_o)] : 32'hDEADBEEF;
        if (bus1.w_rd_en_o)
            bus1.w_rdata_i <= (int'(bus1.w_addr_o) < cfgWSize[1]) ? wMem[1][int'(bus1.w_addr_o)] : 32'hDEADBEEF;
        if (bus1.b_rd_en_o)
            bus1.b_rdata_i <= (int'(bus1.b_addr_o) < cfgBSize[1]) ? bMem[1][int'(bus1.b_addr_o)] : 32'hDEADBEEF;
    end

    // Schedule model: a pass is a cycle count from the first BIAS cycle;
    // start is only taken while no pass is running, and reset ends the pass.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mRun[0] <= 1'b0;
            mRun[1] <= 1'b0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (!mRun[k]) begin
                    if (start) begin
                        mRun[k]    <= 1'b1;
                        mCyc[k]    <= 0;
                        passIdx[k] <= passIdx[k] + 1;
                    end
                end else if (mCyc[k] == cfgPix[k] * (cfgTaps[k] + 3)) begin
                    mRun[k] <= 1'b0;
                end else begin
                    mCyc[k] <= mCyc[k] + 1;
                end
            end
        end
    end

    // Compare process: both DUTs are checked on every falling edge.
    always @(negedge clk) begin
        checkOutput(0, bus0.busy_o, bus0.done_o, bus0.in_rd_en_o, bus0.in_addr_o,
                    bus0.w_rd_en_o, bus0.w_addr_o, bus0.b_rd_en_o, bus0.b_addr_o,
                    bus0.out_we_o, bus0.out_addr_o, bus0.out_data_o);
        checkOutput(1, bus1.busy_o, bus1.done_o, bus1.in_rd_en_o, bus1.in_addr_o,
                    bus1.w_rd_en_o, bus1.w_addr_o, bus1.b_rd_en_o, bus1.b_addr_o,
                    bus1.out_we_o, bus1.out_addr_o, bus1.out_data_o);
    end

    // One comparison: counts it and reports a mismatch.
    task automatic checkVal(input string name, input int k,
                            input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s dut%0d t=%0t: got 0x%08h expected 0x%08h",
                     name, k, $time, act, exp);
        end
    endtask

    // Hand-computed values for the first (directed) pass of each DUT.
    function automatic int litValue(input int k, input int pix);
        return (k == 0) ? 11 : lit1[pix];
    endfunction

    // Predict every bus output of DUT k for the current cycle and compare.
    task automatic checkOutput(input int k, input logic busy, input logic done,
                               input logic inEn, input logic [15:0] inAddr,
                               input logic wEn, input logic [15:0] wAddr,
                               input logic bEn, input logic [15:0] bAddr,
                               input logic we, input logic [15:0] outAddr,
                               input logic [31:0] outData);
        int per, np, c, pix, slot, t, ic, kh, kw, oc, oh, ow, ih, iw;
        bit run, expBusy, expDone, expWe, expB, expW, inb;
        if (rst) begin
            checkVal("resetCtrl", k, 32'({busy, done, inEn, wEn, bEn, we}), 32'd0);
            checkVal("resetAddr", k, 32'(inAddr | wAddr | bAddr | outAddr), 32'd0);
            checkVal("resetData", k, outData, 32'd0);
            return;
        end
        per     = cfgTaps[k] + 3;
        np      = cfgPix[k] * per;
        run     = mRun[k];
        c       = mCyc[k];
        pix     = c / per;
        slot    = c % per;
        expBusy = run && (c < np);
        expDone = run && (c == np);
        expB    = expBusy && (slot == 0);
        expW    = expBusy && (slot >= 1) && (slot <= cfgTaps[k]);
        expWe   = expBusy && (slot == per - 1);
        if (run && c == 0) wrCnt[k] = 0;
        checkVal("busy", k, 32'(busy), 32'(expBusy));
        checkVal("done", k, 32'(done), 32'(expDone));
        checkVal("bRdEn", k, 32'(bEn), 32'(expB));
        checkVal("wRdEn", k, 32'(wEn), 32'(expW));
        checkVal("outWe", k, 32'(we), 32'(expWe));
        oc = pix / (cfgOutH[k] * cfgOutW[k]);
        oh = (pix / cfgOutW[k]) % cfgOutH[k];
        ow = pix % cfgOutW[k];
        if (expB) checkVal("bAddr", k, 32'(bAddr), oc);
        if (expW) begin
            t   = slot - 1;
            ic  = t / (cfgK[k] * cfgK[k]);
            kh  = (t / cfgK[k]) % cfgK[k];
            kw  = t % cfgK[k];
            ih  = oh * cfgStride[k] + kh - cfgPad[k];
            iw  = ow * cfgStride[k] + kw - cfgPad[k];
            inb = (ih >= 0) && (ih < cfgInH[k]) && (iw >= 0) && (iw < cfgInW[k]);
            checkVal("inRdEn", k, 32'(inEn), 32'(inb));
            if (inb)
                checkVal("inAddr", k, 32'(inAddr), ic * cfgInH[k] * cfgInW[k] + ih * cfgInW[k] + iw);
            checkVal("wAddr", k, 32'(wAddr), ((oc * cfgInCh[k] + ic) * cfgK[k] + kh) * cfgK[k] + kw);
        end else begin
            checkVal("inRdEnIdle", k, 32'(inEn), 32'd0);
        end
        if (expWe) begin
            wrCnt[k]++;
            checkVal("outAddr", k, 32'(outAddr), pix);
            checkVal("outData", k, outData, expOut[k][pix]);
            if (passIdx[k] == 0) begin
                checkVal("outDataLiteral", k, outData, litValue(k, pix));
                checkVal("modelLiteral", k, expOut[k][pix], litValue(k, pix));
            end
        end
        if (expDone) begin
            checkVal("writeCount", k, wrCnt[k], cfgPix[k]);
            if (passIdx[k] == 0) checkVal("doneCycle", k, c, doneAtLit[k]);
        end
    endtask

    // Reference convolution: bias plus in-bounds products, 32-bit wrapping.
    task automatic computeExpected(input int k);
        int acc, ih, iw;
        for (int oc = 0; oc < cfgOutCh[k]; oc++)
            for (int oh = 0; oh < cfgOutH[k]; oh++)
                for (int ow = 0; ow < cfgOutW[k]; ow++) begin
                    acc = bMem[k][oc];
                    for (int ic = 0; ic < cfgInCh[k]; ic++)
                        for (int kh = 0; kh < cfgK[k]; kh++)
                            for (int kw = 0; kw < cfgK[k]; kw++) begin
                                ih = oh * cfgStride[k] + kh - cfgPad[k];
                                iw = ow * cfgStride[k] + kw - cfgPad[k];
                                if (ih >= 0 && ih < cfgInH[k] && iw >= 0 && iw < cfgInW[k])
                                    acc += inMem[k][ic * cfgInH[k] * cfgInW[k] + ih * cfgInW[k] + iw]
                                           * wMem[k][((oc * cfgInCh[k] + ic) * cfgK[k] + kh) * cfgK[k] + kw];
                            end
                    expOut[k][(oc * cfgOutH[k] + oh) * cfgOutW[k] + ow] = acc;
                end
    endtask

    // Fill memories (directed pattern or random) and refresh the model.
    task automatic loadMemories(input bit directed);
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 32; i++) inMem[k][i] = directed ? 1 : int'($urandom);
            for (int i = 0; i < 8; i++)  wMem[k][i]  = directed ? 1 : int'($urandom);
            for (int i = 0; i < 2; i++)  bMem[k][i]  = int'($urandom);
        end
        if (directed) begin
            bMem[0][0] = 3;
            for (int i = 0; i < 4; i++) inMem[1][i] = i + 1;
            bMem[1][0] = 0;
            bMem[1][1] = -10;
        end
        computeExpected(0);
        computeExpected(1);
    endtask

    // Raise start for the given number of cycles, changing it on falling edges.
    task automatic applyStimulus(input int holdCycles);
        @(negedge clk);
        start = 1'b1;
        repeat (holdCycles) @(negedge clk);
        start = 1'b0;
    endtask

    // Main sequence: directed pass, ignored restart, random passes,
    // back-to-back passes, reset mid-pass, recovery pass.
    initial begin
        rst   = 1'b0;
        start = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        loadMemories(1'b1);
        applyStimulus(1);
        repeat (10) @(negedge clk);
        applyStimulus(1);
        repeat (130) @(negedge clk);

        for (int n = 0; n < 3; n++) begin
            loadMemories(1'b0);
            applyStimulus(1);
            repeat (135) @(negedge clk);
        end

        loadMemories(1'b0);
        applyStimulus(140);
        repeat (135) @(negedge clk);

        loadMemories(1'b0);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (26) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        loadMemories(1'b0);
        applyStimulus(1);
        repeat (135) @(negedge clk);

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
